// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and a later companion receiver.
// Holds the line state encoding and the bit-timing divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned DATA_BITS = 8;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on data_o while not empty.
// A push is accepted when full only together with a pop, so the level stays unchanged.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: storage carries no reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter (8N1 or 8E1) fed from a small FWFT FIFO over a valid/ready handshake.
// Bit timing comes from an integer divider of the system clock.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 8000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter bit          PARITY_EN   = 1'b0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_divider
        $error("uart_tx: CLKS_PER_BIT=%0d is below the minimum of 4", CLKS_PER_BIT);
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH=%0d must be a power of two, at least 2", FIFO_DEPTH);
    end

    uart_state_e      state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic             tx_q;
    logic             busy_q;

    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             bit_end;

    // Ready is held low during reset so nothing is accepted into a FIFO that is being flushed.
    assign tx_ready_o = !fifo_full && !reset;
    assign push       = tx_valid_i && tx_ready_o;
    assign bit_end    = (baud_cnt_q == CNT_LAST);
    assign pop        = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && bit_end));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (tx_data_i),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    // NOTE: all state and outputs update with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            baud_cnt_q <= (state_q == IDLE || bit_end) ? '0 : baud_cnt_q + CNT_W'(1);
            busy_q     <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_q  <= fifo_data;
                        parity_q <= ^fifo_data;
                        tx_q     <= 1'b0;
                        state_q  <= START;
                    end else begin
                        tx_q   <= 1'b1;
                        busy_q <= push;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= PARITY_EN ? parity_q : 1'b1;
                            state_q <= PARITY_EN ? PARITY : STOP;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        // Back-to-back frames: the next start bit follows the stop bit directly.
                        if (!fifo_empty) begin
                            shift_q  <= fifo_data;
                            parity_q <= ^fifo_data;
                            tx_q     <= 1'b0;
                            state_q  <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            busy_q  <= push;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (8N1 default, 8E1, 4-cycle divider) exercised in turn.
// A line decoder monitor rebuilds each frame from tx_o and compares it against the queue of accepted bytes.
module tb_uart_tx;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       vld [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] din [3] = '{8'h00, 8'h00, 8'h00};
    logic       rdy [3];
    logic       txl [3];
    logic       bsy [3];
    logic [2:0] lvl [3];

    int cyc = 0;
    int phase = 0;
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q [$];
    bit   mon_kill = 1'b0;
    int   b2b_frames = 0;
    int   last_end = -100;
    logic last_par = 1'bx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx u_dflt (
        .clk(clk), .reset(reset), .tx_data_i(din[0]), .tx_valid_i(vld[0]), .tx_ready_o(rdy[0]),
        .tx_o(txl[0]), .busy_o(bsy[0]), .fifo_level_o(lvl[0])
    );
    uart_tx #(.PARITY_EN(1'b1)) u_par (
        .clk(clk), .reset(reset), .tx_data_i(din[1]), .tx_valid_i(vld[1]), .tx_ready_o(rdy[1]),
        .tx_o(txl[1]), .busy_o(bsy[1]), .fifo_level_o(lvl[1])
    );
    uart_tx #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(250000)) u_fast (
        .clk(clk), .reset(reset), .tx_data_i(din[2]), .tx_valid_i(vld[2]), .tx_ready_o(rdy[2]),
        .tx_o(txl[2]), .busy_o(bsy[2]), .fifo_level_o(lvl[2])
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Offer one byte; the expected frame is queued on the edge that accepts it.
    task automatic push_byte(input int inst, input logic [7:0] b, input bit keep, output int acc);
        int n = 0;
        acc = -1;
        din[inst] = b;
        vld[inst] = 1'b1;
        while (n < 2000) begin
            if (rdy[inst] === 1'b1) begin
                acc = cyc + 1;
                exp_q.push_back(b);
                @(negedge clk);
                break;
            end
            @(negedge clk);
            n++;
        end
        if (!keep || acc < 0) vld[inst] = 1'b0;
        check("push_accepted", acc >= 0, 1);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(input int inst, input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || bsy[inst] !== 1'b0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", n < limit, 1);
    endtask

    // Line decoder: samples every cycle, requires each bit to hold for a whole bit period.
    initial begin : monitor
        int nbits;
        int cpb;
        int glitches;
        bit aborted;
        logic [10:0] bits;
        logic [7:0] data;
        forever begin
            @(negedge clk);
            if (!mon_kill && txl[phase] === 1'b0) begin
                nbits    = (phase == 1) ? 11 : 10;
                cpb      = (phase == 2) ? 4 : 69;
                glitches = 0;
                aborted  = 1'b0;
                bits     = '1;
                if (cyc == last_end + 1) b2b_frames++;
                for (int b = 0; b < nbits; b++) begin
                    for (int c = 0; c < cpb; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (mon_kill) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) bits[b] = txl[phase];
                        else if (txl[phase] !== bits[b]) glitches++;
                    end
                    if (aborted) break;
                end
                last_end = cyc;
                if (!aborted) begin
                    data = bits[8:1];
                    check("start_bit", bits[0], 0);
                    check("bit_width", glitches, 0);
                    check("stop_bit", bits[nbits-1], 1);
                    if (phase == 1) begin
                        last_par = bits[9];
                        check("parity_bit", bits[9], $countones(data) % 2);
                    end
                    if (exp_q.size() == 0) check("unexpected_frame", data, 32'hffff_ffff);
                    else check("frame_data", data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a;
        int a1;
        int a2;
        int b2b0;
        int lows;

        repeat (3) @(negedge clk);
        check("rst_tx", txl[0], 1);
        check("rst_busy", bsy[0], 0);
        check("rst_level", lvl[0], 0);
        check("rst_ready_low", rdy[0], 0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", rdy[0], 1);
        @(negedge clk);

        // Single 0x55 frame: latency, bit pattern, busy release.
        push_byte(0, 8'h55, 1'b0, a);
        check("t1_line_idle_after_accept", txl[0], 1);
        @(negedge clk);
        check("t1_start_after_pop", txl[0], 0);
        wait_until(a + 690);
        check("t1_busy_in_stop", bsy[0], 1);
        check("t1_line_in_stop", txl[0], 1);
        wait_until(a + 691);
        check("t1_busy_cleared", bsy[0], 0);
        drain(0, 1000);

        for (int i = 0; i < 4; i++) begin
            push_byte(0, 8'($urandom), 1'b0, a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain(0, 4000);

        // Backpressure: valid held with 0x01..0x06.
        b2b0 = b2b_frames;
        push_byte(0, 8'h01, 1'b1, a1);
        for (int i = 2; i <= 6; i++) begin
            push_byte(0, 8'(i), i != 6, a);
            if (i == 5) begin
                check("t3_fifth_accept_cycle", a, a1 + 4);
                check("t3_level_full", lvl[0], 4);
                check("t3_ready_low_when_full", rdy[0], 0);
            end
            if (i == 6) check("t3_sixth_after_second_pop", a, a1 + 692);
        end
        drain(0, 5000);
        check("t3_back_to_back", b2b_frames - b2b0, 5);

        // Push on the same edge as the stop-end pop with one entry queued.
        push_byte(0, 8'hC3, 1'b0, a);
        push_byte(0, 8'h3C, 1'b0, a2);
        check("t5_level_one", lvl[0], 1);
        wait_until(a + 690);
        check("t5_level_before", lvl[0], 1);
        push_byte(0, 8'h96, 1'b0, a2);
        check("t5_accept_on_pop_edge", a2, a + 691);
        check("t5_level_unchanged", lvl[0], 1);
        drain(0, 2500);

        // Reset during data bit 3 of 0xA5 with two bytes queued.
        push_byte(0, 8'hA5, 1'b0, a);
        push_byte(0, 8'h11, 1'b0, a2);
        push_byte(0, 8'h22, 1'b0, a2);
        check("t4_level_queued", lvl[0], 2);
        wait_until(a + 300);
        mon_kill = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t4_tx_idle", txl[0], 1);
        check("t4_level_flushed", lvl[0], 0);
        check("t4_busy_cleared", bsy[0], 0);
        check("t4_ready_back", rdy[0], 1);
        exp_q.delete();
        lows = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) lows++;
        end
        check("t4_no_restart", lows, 0);
        mon_kill = 1'b0;

        // Even parity instance.
        phase = 1;
        push_byte(1, 8'h07, 1'b0, a);
        wait_until(a + 759);
        check("t2_busy_in_stop", bsy[1], 1);
        wait_until(a + 760);
        check("t2_busy_cleared", bsy[1], 0);
        check("t2_parity_07", last_par, 1);
        push_byte(1, 8'h03, 1'b0, a);
        drain(1, 1000);
        check("t2_parity_03", last_par, 0);
        for (int i = 0; i < 3; i++) push_byte(1, 8'($urandom), i != 2, a);
        drain(1, 3000);

        // Four-cycle bit period instance.
        phase = 2;
        push_byte(2, 8'h5A, 1'b0, a);
        @(negedge clk);
        check("t6_start_after_pop", txl[2], 0);
        wait_until(a + 40);
        check("t6_busy_in_stop", bsy[2], 1);
        wait_until(a + 41);
        check("t6_busy_cleared", bsy[2], 0);
        b2b0 = b2b_frames;
        for (int i = 0; i < 8; i++) push_byte(2, 8'($urandom), i != 7, a);
        drain(2, 1000);
        check("t6_back_to_back", b2b_frames - b2b0, 7);

        check("leftover_expected", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
